// File: rtl/unsigned_mul_8x8_ha_array_accum.sv
// Accumulates four pre-reduced half-adder array rows into a saturated 16-bit product,
// summing ROWS_PER_CYCLE rows per clock behind a valid/ready handshake on each side.
module unsigned_mul_8x8_ha_array_accum #(
  parameter int unsigned ROWS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] product,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : gen_bad_rpc
    $error("ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [2:0] RowStep = 3'(ROWS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e      state_q, state_d;
  logic        armed_q;
  logic [2:0]  idx_q, idx_d;
  logic [16:0] acc_q, acc_d;
  logic [6:0]  b_q [4];
  logic [8:0]  t_q [4];
  logic [10:0] row_val [4];
  logic [16:0] row_sum;
  logic        accept;

  // armed_q holds in_ready low until the first edge after reset release
  assign in_ready  = armed_q && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign product   = !out_valid ? 16'h0000 : (acc_q[16] ? 16'hFFFF : acc_q[15:0]);
  assign ovf       = out_valid && acc_q[16];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      row_val[k] = {2'b00, t_q[k]} + {2'b00, b_q[k], 2'b00};
    end
  end

  // Sum only the rows in the window [idx_q, idx_q + ROWS_PER_CYCLE)
  always_comb begin
    row_sum = '0;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(idx_q) && k < int'(idx_q) + int'(ROWS_PER_CYCLE)) begin
        row_sum = row_sum + (17'(row_val[k]) << (2 * k));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAcc;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      StAcc: begin
        acc_d = acc_q + row_sum;
        idx_d = idx_q + RowStep;
        if (idx_q + RowStep == 3'd4) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      armed_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        b_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      if (accept) begin
        b_q[0] <= ha_array_0_b;
        b_q[1] <= ha_array_1_b;
        b_q[2] <= ha_array_2_b;
        b_q[3] <= ha_array_3_b;
        t_q[0] <= ha_array_0_t;
        t_q[1] <= ha_array_1_t;
        t_q[2] <= ha_array_2_t;
        t_q[3] <= ha_array_3_t;
      end
    end
  end

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_accum.sv
// Random and directed bench for the row accumulator; three instances cover
// ROWS_PER_CYCLE = 1, 2 and 4, checked against a plain-arithmetic model.
module tb_unsigned_mul_8x8_ha_array_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  b_in [4];
  logic [8:0]  t_in [4];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] product   [3];
  logic        ovf       [3];
  logic        out_valid [3];
  logic        out_ready [3];

  int checks = 0;
  int errors = 0;
  bit          pending  [3];
  logic [15:0] exp_prod [3];
  logic        exp_ovf  [3];
  logic [15:0] last_prod [3];
  logic        last_ovf  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    unsigned_mul_8x8_ha_array_accum #(.ROWS_PER_CYCLE(1 << g)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ha_array_0_b (b_in[0]),
      .ha_array_1_b (b_in[1]),
      .ha_array_2_b (b_in[2]),
      .ha_array_3_b (b_in[3]),
      .ha_array_0_t (t_in[0]),
      .ha_array_1_t (t_in[1]),
      .ha_array_2_t (t_in[2]),
      .ha_array_3_t (t_in[3]),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .product      (product[g]),
      .ovf          (ovf[g]),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g])
    );
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Exact sum of all bit weights, in ordinary integer arithmetic.
  function automatic int model_sum();
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      s += (int'(t_in[k]) + 4 * int'(b_in[k])) * (1 << (2 * k));
    end
    return s;
  endfunction

  task automatic set_inputs(input bit ones);
    for (int k = 0; k < 4; k++) begin
      b_in[k] = ones ? 7'h7F : 7'h00;
      t_in[k] = ones ? 9'h1FF : 9'h000;
    end
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < 4; k++) begin
      b_in[k] = 7'($urandom);
      t_in[k] = 9'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the instance idle.
  task automatic run_op(input int i, input int hold, input bit spam);
    int s;
    int lat;
    logic [15:0] p0;
    logic        o0;
    s = model_sum();
    exp_prod[i] = (s > 65535) ? 16'hFFFF : 16'(s);
    exp_ovf[i]  = (s > 65535);
    chk("in_ready_idle", i, 32'(in_ready[i]), 32'd1);
    in_valid[i] = 1'b1;
    tick();
    in_valid[i] = spam;
    pending[i]  = 1'b1;
    randomize_inputs();  // latched copies must be used from here on
    lat = 0;
    while (!out_valid[i] && lat < 20) begin
      chk("in_ready_busy", i, 32'(in_ready[i]), 32'd0);
      tick();
      randomize_inputs();
      lat++;
    end
    chk("latency", i, 32'(lat), 32'(4 >> i));
    if (!out_valid[i]) begin
      in_valid[i] = 1'b0;
      return;
    end
    p0 = product[i];
    o0 = ovf[i];
    for (int h = 0; h < hold; h++) begin
      tick();
      randomize_inputs();
      chk("hold_valid", i, 32'(out_valid[i]), 32'd1);
      chk("hold_ready", i, 32'(in_ready[i]), 32'd0);
      chk("hold_prod", i, 32'(product[i]), 32'(p0));
      chk("hold_ovf", i, 32'(ovf[i]), 32'(o0));
    end
    last_prod[i] = product[i];
    last_ovf[i]  = ovf[i];
    out_ready[i] = 1'b1;
    tick();
    out_ready[i] = 1'b0;
    in_valid[i]  = 1'b0;
    pending[i]   = 1'b0;
    chk("after_xfer_valid", i, 32'(out_valid[i]), 32'd0);
    chk("after_xfer_ready", i, 32'(in_ready[i]), 32'd1);
    tick();
    chk("idle_stays", i, 32'(in_ready[i]), 32'd1);
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      chk("rst_product", i, 32'(product[i]), 32'd0);
      chk("rst_ovf", i, 32'(ovf[i]), 32'd0);
      chk("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
      chk("rst_in_ready", i, 32'(in_ready[i]), 32'd0);
    end
  endtask

  // Single compare process: any asserted out_valid must belong to an accepted operation
  // and carry the model's result.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && out_valid[i]) begin
        chk("out_valid_expected", i, 32'(pending[i]), 32'd1);
        if (pending[i]) begin
          chk("product", i, 32'(product[i]), 32'(exp_prod[i]));
          chk("ovf", i, 32'(ovf[i]), 32'(exp_ovf[i]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      pending[i]   = 1'b0;
    end
    set_inputs(1'b0);
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("ready_before_edge", 0, 32'(in_ready[0]), 32'd0);
    tick();

    set_inputs(1'b1);
    chk("model_all_ones", 0, 32'(model_sum()), 32'd86615);

    for (int i = 0; i < 3; i++) begin
      set_inputs(1'b0);
      run_op(i, 0, 1'b0);
      chk("lit_zero", i, 32'(last_prod[i]), 32'h0000);
      chk("lit_zero_ovf", i, 32'(last_ovf[i]), 32'd0);
      set_inputs(1'b0);
      t_in[0] = 9'h001;
      run_op(i, 0, 1'b0);
      chk("lit_t0_lsb", i, 32'(last_prod[i]), 32'h0001);
      set_inputs(1'b0);
      b_in[3] = 7'h40;
      run_op(i, 1, 1'b1);
      chk("lit_b3_msb", i, 32'(last_prod[i]), 32'h4000);
      set_inputs(1'b1);
      run_op(i, 5, 1'b0);
      chk("lit_all_ones", i, 32'(last_prod[i]), 32'hFFFF);
      chk("lit_all_ones_ovf", i, 32'(last_ovf[i]), 32'd1);
    end

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 3; i++) begin
        randomize_inputs();
        run_op(i, int'($urandom_range(0, 3)), 1'($urandom));
      end
    end

    // Abort mid-accumulation on the one-row-per-cycle instance.
    set_inputs(1'b1);
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    pending[0]  = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    chk("abort_ready_low", 0, 32'(in_ready[0]), 32'd0);
    tick();
    chk("abort_ready_high", 0, 32'(in_ready[0]), 32'd1);
    for (int c = 0; c < 8; c++) begin
      chk("abort_no_valid", 0, 32'(out_valid[0]), 32'd0);
      tick();
    end
    randomize_inputs();
    run_op(0, 2, 1'b0);
    set_inputs(1'b0);
    t_in[0] = 9'h001;
    run_op(0, 0, 1'b0);
    chk("post_abort_lit", 0, 32'(last_prod[0]), 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unsigned_mul_8x8_ha_array_accum.md
UNSIGNED_MUL_8X8_HA_ARRAY_ACCUM -- requirements
Module: unsigned_mul_8x8_ha_array_accum

Interface
REQ-001 SHALL have parameter ROWS_PER_CYCLE, default 1, meaning ha_array rows summed per accumulate cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion and active-low.
REQ-004 SHALL have ports ha_array_k_b  input  7, for k = 0..3, meaning carry bits of row k; bit i has weight 2^(i+2+2k).
REQ-005 SHALL have ports ha_array_k_t  input  9, for k = 0..3, meaning sum bits of row k; bit i has weight 2^(i+2k).
REQ-006 SHALL have port in_valid  input  1  meaning all eight ha_array inputs are valid.
REQ-007 SHALL have port in_ready  output  1  meaning the block can accept a new operand set.
REQ-008 SHALL have port product  output  16  approximate product, saturated.
REQ-009 SHALL have port ovf  output  1  meaning the unsaturated sum exceeded 16'hFFFF.
REQ-010 SHALL have port out_valid  input-side handshake partner out_ready; out_valid  output  1, out_ready  input  1.

Function
REQ-011 SHALL compute row value R_k = t_k + (b_k << 2), 11 bits, and sum S = sum over k of (R_k << 2k) in a 17-bit accumulator.
REQ-012 SHALL implement states IDLE, ACC, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, latch all eight inputs, clear accumulator, clear row index, go to ACC.
REQ-014 ACC: in_ready=0; each cycle add the next ROWS_PER_CYCLE latched rows in order k=0..3 and advance the row index.
REQ-015 SHALL leave ACC for DONE on the edge that adds row 3; latency from accepting edge to out_valid=1 is 4/ROWS_PER_CYCLE cycles.
REQ-016 DONE: out_valid=1, in_ready=0; product = S[16] ? 16'hFFFF : S[15:0]; ovf = S[16].
REQ-017 In DONE, product and ovf SHALL stay stable while out_ready=0.
REQ-018 On out_valid&out_ready, SHALL return to IDLE; no back-to-back acceptance in the same edge.
REQ-019 Inputs changing while in ACC or DONE SHALL have no effect; only latched values are used.
REQ-020 in_valid while not in IDLE SHALL be ignored and not queued.
REQ-021 Row index SHALL not wrap past 3; ACC never adds a row twice.
REQ-022 Illegal ROWS_PER_CYCLE values SHALL cause an elaboration-time error.

Reset
REQ-023 While rst_n=0, SHALL force state IDLE, accumulator 0, latched rows 0, product 0, ovf 0, out_valid 0, in_ready 0.
REQ-024 First rising edge after rst_n deasserts SHALL set in_ready=1.
REQ-025 Reset asserted during ACC or DONE SHALL abort the operation; no partial product is ever presented.

Verification
REQ-026 All inputs 0, ROWS_PER_CYCLE=1 -> out_valid 4 cycles after accept, product=16'h0000, ovf=0.
REQ-027 Only ha_array_0_t=9'h001 -> product=16'h0001; only ha_array_3_b[6]=1 -> product=16'h4000.
REQ-028 All b and t bits 1 -> S=86615 -> product=16'hFFFF, ovf=1.
REQ-029 out_ready held 0 for 5 cycles in DONE -> product/ovf stable, in_ready=0, single transfer on release, then IDLE.
REQ-030 rst_n pulsed low mid-ACC -> out_valid never asserts for that operand set; all outputs 0; next operation correct.
REQ-031 Repeat REQ-026..028 with ROWS_PER_CYCLE=2 and 4 -> same results, latency 2 and 1 cycles.
